// File: rtl/strategy_sequencer.sv
// rtl/strategy_sequencer.sv - steps the strategy mux through a programmed run table
// Each entry runs its strategy a set number of times, parking on IDLE_SEL between runs.
module strategy_sequencer #(
    parameter int         DEPTH          = 8,
    parameter int         NUM_STRATEGIES = 5,
    parameter int         GAP_CYCLES     = 4,
    parameter logic [7:0] IDLE_SEL       = 8'hFF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [7:0]                 wr_strategy,
    input  logic [15:0]                wr_repeat,
    input  logic [$clog2(DEPTH):0]     length,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       run_done,
    output logic [7:0]                 strategy_sel,
    output logic                       run_start,
    output logic                       busy,
    output logic                       seq_done,
    output logic                       aborted,
    output logic                       error,
    output logic [$clog2(DEPTH)-1:0]   cur_index,
    output logic [15:0]                cur_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [8:0]    NUM_L    = 9'(NUM_STRATEGIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    tbl_strat_q [DEPTH];
    logic [15:0]   tbl_rep_q   [DEPTH];

    logic [LW-1:0] len_q,   len_d;
    logic [LW-1:0] index_q, index_d;
    logic [15:0]   count_q, count_d;
    logic [GW-1:0] gap_q,   gap_d;

    logic [7:0]    sel_q,       sel_d;
    logic          run_start_q, run_start_d;
    logic          busy_q,      busy_d;
    logic          seq_done_q,  seq_done_d;
    logic          aborted_q,   aborted_d;
    logic          error_q,     error_d;

    logic [7:0]    entry_strat;
    logic [15:0]   entry_rep;
    logic [LW-1:0] idx_inc;
    logic [15:0]   cnt_inc;
    logic          bad_len;
    logic          bad_strat;
    logic          last_entry;
    logic          entry_finished;
    logic          abort_hit;

    // The table is only writable while idle, so the entry under index_q is stable during a sequence.
    assign entry_strat    = tbl_strat_q[index_q[AW-1:0]];
    assign entry_rep      = tbl_rep_q[index_q[AW-1:0]];
    assign idx_inc        = index_q + LW'(1);
    assign cnt_inc        = count_q + 16'd1;
    assign bad_len        = (length == '0) || (length > DEPTH_L);
    assign bad_strat      = ({1'b0, entry_strat} >= NUM_L);
    assign last_entry     = (idx_inc == len_q);
    assign entry_finished = (cnt_inc == entry_rep);
    assign abort_hit      = abort && (state_q != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_strat_q[i] <= 8'd0;
                tbl_rep_q[i]   <= 16'd0;
            end
        end else if (wr_en && (state_q == S_IDLE)) begin
            tbl_strat_q[wr_addr] <= wr_strategy;
            tbl_rep_q[wr_addr]   <= wr_repeat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !bad_len) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bad_strat) begin
                        state_d = S_IDLE;
                    end else if (entry_rep == 16'd0) begin
                        state_d = last_entry ? S_DONE : S_LOAD;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_done) begin
                        state_d = (entry_finished && last_entry) ? S_DONE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_LOAD;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_d       = sel_q;
        run_start_d = 1'b0;
        seq_done_d  = 1'b0;
        aborted_d   = 1'b0;
        error_d     = 1'b0;
        busy_d      = (state_d != S_IDLE);
        len_d       = len_q;
        index_d     = index_q;
        count_d     = count_q;
        gap_d       = gap_q;
        if (abort_hit) begin
            sel_d     = IDLE_SEL;
            aborted_d = 1'b1;
            index_d   = '0;
            count_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sel_d = IDLE_SEL;
                    if (start) begin
                        if (bad_len) begin
                            error_d = 1'b1;
                        end else begin
                            len_d   = length;
                            index_d = '0;
                            count_d = '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (bad_strat) begin
                        error_d = 1'b1;
                        sel_d   = IDLE_SEL;
                        index_d = '0;
                        count_d = '0;
                    end else if (entry_rep == 16'd0) begin
                        index_d    = idx_inc;
                        count_d    = '0;
                        seq_done_d = last_entry;
                    end else begin
                        sel_d       = entry_strat;
                        run_start_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_done) begin
                        sel_d = IDLE_SEL;
                        gap_d = '0;
                        if (entry_finished) begin
                            index_d    = idx_inc;
                            count_d    = '0;
                            seq_done_d = last_entry;
                        end else begin
                            count_d = cnt_inc;
                        end
                    end
                end
                S_GAP: begin
                    sel_d = IDLE_SEL;
                    gap_d = gap_q + GW'(1);
                end
                S_DONE:  sel_d = IDLE_SEL;
                default: sel_d = IDLE_SEL;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q       <= '0;
            index_q     <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            sel_q       <= IDLE_SEL;
            run_start_q <= 1'b0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            aborted_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            len_q       <= len_d;
            index_q     <= index_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            sel_q       <= sel_d;
            run_start_q <= run_start_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
            aborted_q   <= aborted_d;
            error_q     <= error_d;
        end
    end

    assign strategy_sel = sel_q;
    assign run_start    = run_start_q;
    assign busy         = busy_q;
    assign seq_done     = seq_done_q;
    assign aborted      = aborted_q;
    assign error        = error_q;
    assign cur_index    = index_q[AW-1:0];
    assign cur_count    = count_q;

endmodule

// File: tb/tb_strategy_sequencer.sv
// tb/tb_strategy_sequencer.sv - directed scoreboard bench for strategy_sequencer
module tb_strategy_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_strategy;
    logic [15:0] wr_repeat;
    logic [3:0]  length;
    logic        start;
    logic        abort;
    logic        run_done;
    logic [7:0]  strategy_sel;
    logic        run_start;
    logic        busy;
    logic        seq_done;
    logic        aborted;
    logic        error;
    logic [2:0]  cur_index;
    logic [15:0] cur_count;

    logic        rd_auto = 1'b0;
    logic        rd_man  = 1'b0;
    logic        resp_en = 1'b1;
    assign run_done = rd_auto | rd_man;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_at  = -1;
    logic [7:0] prev_sel = 8'hFF;

    // Queue 0: run_start cycles, 1: seq_done, 2: error, 3: aborted.
    int exp_q [4][$];
    int exp_rs_sel [$];
    int hist [$];

    strategy_sequencer #(
        .DEPTH(8), .NUM_STRATEGIES(5), .GAP_CYCLES(4), .IDLE_SEL(8'hFF)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_strategy(wr_strategy), .wr_repeat(wr_repeat), .length(length),
        .start(start), .abort(abort), .run_done(run_done),
        .strategy_sel(strategy_sel), .run_start(run_start), .busy(busy),
        .seq_done(seq_done), .aborted(aborted), .error(error),
        .cur_index(cur_index), .cur_count(cur_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int hp(input int c, input int s);
        return (c << 8) | s;
    endfunction

    task automatic mon_pulse(input int k, input logic p, input string tag);
        if (p) begin
            if (exp_q[k].size() == 0) check({tag, "_unexpected"}, 1, 0);
            else check(tag, cyc, exp_q[k].pop_front());
        end
    endtask

    always @(negedge clock) begin
        if (strategy_sel !== prev_sel) begin
            check("sel_via_idle", 32'((prev_sel != 8'hFF) && (strategy_sel != 8'hFF)), 0);
            hist.push_back(hp(cyc, int'(strategy_sel)));
            prev_sel = strategy_sel;
        end
        if (run_start) begin
            if (exp_q[0].size() == 0) begin
                check("run_start_unexpected", 1, 0);
            end else begin
                check("run_start_cycle", cyc, exp_q[0].pop_front());
                check("run_start_sel", 32'(strategy_sel), exp_rs_sel.pop_front());
            end
            done_at = cyc + 10;
        end
        mon_pulse(1, seq_done, "seq_done_cycle");
        mon_pulse(2, error, "error_cycle");
        mon_pulse(3, aborted, "aborted_cycle");
        rd_auto = resp_en && (cyc == done_at);
    end

    task automatic expect_rs(input int c, input int s);
        exp_q[0].push_back(c);
        exp_rs_sel.push_back(s);
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [7:0] s, input logic [15:0] r);
        wr_en = 1'b1; wr_addr = a; wr_strategy = s; wr_repeat = r;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic drive_start(input logic [3:0] len);
        start = 1'b1; length = len;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int when);
        when = -1;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                when = cyc;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic drained(input string tag);
        for (int k = 0; k < 4; k++) begin
            check(tag, exp_q[k].size(), 0);
            exp_q[k].delete();
        end
        exp_rs_sel.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int when;
        int eh [6];
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_strategy = '0; wr_repeat = '0;
        length = '0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {strategy_sel, run_start, busy, seq_done, aborted, error, cur_index, cur_count}, 32'hFF00_0000);
        reset = 1'b1;
        @(negedge clock);

        // Two entries, three runs; a write and a start while busy must both be ignored.
        write_entry(3'd0, 8'd0, 16'd2);
        write_entry(3'd1, 8'd1, 16'd1);
        hist.delete();
        t = cyc;
        expect_rs(t + 2, 0); expect_rs(t + 18, 0); expect_rs(t + 34, 1);
        exp_q[1].push_back(t + 45);
        drive_start(4'd2);
        repeat (4) @(negedge clock);
        wr_en = 1'b1; wr_addr = 3'd1; wr_strategy = 8'd7; wr_repeat = 16'd0;
        @(negedge clock);
        wr_en = 1'b0; start = 1'b1; length = 4'd0;
        @(negedge clock);
        start = 1'b0;
        wait_idle(when);
        check("t1_busy_low", when, t + 46);
        eh = '{hp(t + 2, 0), hp(t + 13, 255), hp(t + 18, 0), hp(t + 29, 255), hp(t + 34, 1), hp(t + 45, 255)};
        check("t1_hist_len", hist.size(), 6);
        for (int i = 0; i < 6; i++) check("t1_sel_hist", (i < hist.size()) ? hist[i] : -1, eh[i]);
        drained("t1_pending");

        // Skipped entry adds one LOAD cycle.
        write_entry(3'd0, 8'd0, 16'd0);
        write_entry(3'd1, 8'd4, 16'd1);
        hist.delete();
        t = cyc;
        expect_rs(t + 3, 4);
        exp_q[1].push_back(t + 14);
        drive_start(4'd2);
        wait_idle(when);
        check("t2_busy_low", when, t + 15);
        check("t2_first_sel", (hist.size() > 0) ? hist[0] : -1, hp(t + 3, 4));
        drained("t2_pending");

        // Illegal strategy code in the table; abort while idle must be ignored.
        write_entry(3'd0, 8'd7, 16'd1);
        hist.delete();
        t = cyc;
        exp_q[2].push_back(t + 2);
        drive_start(4'd1);
        @(negedge clock);
        check("t3_busy_low", busy, 1'b0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat (3) @(negedge clock);
        check("t3_sel_stays_idle", hist.size(), 0);
        drained("t3_pending");

        // Bad lengths: zero and above DEPTH.
        t = cyc;
        exp_q[2].push_back(t + 1);
        drive_start(4'd0);
        check("t4_len0_busy", busy, 1'b0);
        t = cyc;
        exp_q[2].push_back(t + 1);
        drive_start(4'd9);
        check("t4_len9_busy", busy, 1'b0);
        @(negedge clock);
        drained("t4_pending");

        // Abort coinciding with run_done after one completed run.
        write_entry(3'd0, 8'd2, 16'd3);
        resp_en = 1'b0;
        t = cyc;
        expect_rs(t + 2, 2); expect_rs(t + 10, 2);
        exp_q[3].push_back(t + 13);
        drive_start(4'd1);
        repeat (3) @(negedge clock);
        rd_man = 1'b1;
        @(negedge clock);
        rd_man = 1'b0;
        check("t5_count_after_run", cur_count, 16'd1);
        repeat (7) @(negedge clock);
        abort = 1'b1; rd_man = 1'b1;
        @(negedge clock);
        abort = 1'b0; rd_man = 1'b0;
        check("t5_after_abort", {strategy_sel, busy, cur_count}, {8'hFF, 1'b0, 16'd0});
        repeat (20) @(negedge clock);
        drained("t5_pending");
        resp_en = 1'b1;
        write_entry(3'd0, 8'd2, 16'd1);
        t = cyc;
        expect_rs(t + 2, 2);
        exp_q[1].push_back(t + 13);
        drive_start(4'd1);
        wait_idle(when);
        check("t5_restart_busy_low", when, t + 14);
        drained("t5_restart_pending");

        // Asynchronous reset in the middle of a gap clears outputs and the table.
        write_entry(3'd0, 8'd3, 16'd2);
        write_entry(3'd1, 8'd1, 16'd1);
        t = cyc;
        expect_rs(t + 2, 3);
        drive_start(4'd1);
        repeat (13) @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_async_reset_outputs", {strategy_sel, run_start, busy, seq_done, aborted, error, cur_index, cur_count}, 32'hFF00_0000);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        t = cyc;
        exp_q[1].push_back(t + 2);
        drive_start(4'd1);
        wait_idle(when);
        check("t6_len1_busy_low", when, t + 3);
        t = cyc;
        exp_q[1].push_back(t + 3);
        drive_start(4'd2);
        wait_idle(when);
        check("t6_len2_busy_low", when, t + 4);
        @(negedge clock);
        drained("t6_pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
